binary_game_input_ctrl: RTL and testbench

- Front end that produces the user-input interface consumed by binary_game. Drives Select, Quit, selectLeft, selectRight and userNumber[7:0].
- Takes raw, bouncing, asynchronous board buttons and slide switches.
- Synchronises and debounces them, then emits clean one-cycle command pulses and a stable, debounced 8-bit number.
- Sits between board I/O pins and binary_game, in the same Clk domain.

---
 rtl/binary_game_input_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_binary_game_input_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/binary_game_input_ctrl.sv
// binary_game_input_ctrl: sync + debounce of board buttons and switches
// feeding binary_game with clean one-cycle commands and a stable number.
//
// Ports:
//   Clk, Reset (async, active-low)
//   btnSelect/btnQuit/btnLeft/btnRight : raw buttons, active-high
//   sw[7:0]                            : raw slide switches
//   Select/Quit/selectLeft/selectRight : one-cycle command pulses
//   userNumber[7:0], numberChanged     : debounced switches + update pulse
// Optional: define AUTOREPEAT_EN for held Left/Right auto-repeat.

module binary_game_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_CYCLES   = 12500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btnSelect,
  input  logic       btnQuit,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic [7:0] sw,
  output logic       Select,
  output logic       Quit,
  output logic       selectLeft,
  output logic       selectRight,
  output logic [7:0] userNumber,
  output logic       numberChanged
);

  if (DEBOUNCE_CYCLES < 2 ||
      (DEBOUNCE_CYCLES >> CNT_W) != 0 ||
      REPEAT_CYCLES < 1) begin : g_bad_param
    $error("binary_game_input_ctrl: bad parameters");
  end

  localparam logic [CNT_W-1:0] CntMax =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, ARMING, HELD, RELEASING
  } btn_state_e;

  // Buttons: 0 Select, 1 Quit, 2 Left, 3 Right; sw in [11:4]
  logic [11:0] meta_q, sync_q;
  logic [3:0]  btn_s;
  logic [7:0]  sw_s;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {sw, btnRight, btnLeft, btnQuit, btnSelect};
      sync_q <= meta_q;
    end
  end

  assign btn_s = sync_q[3:0];
  assign sw_s  = sync_q[11:4];

  btn_state_e       state_q [4];
  btn_state_e       state_d [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       press;

  // Reset lands in HELD so a button held through reset release must
  // first be seen released before it can arm again.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= HELD;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (btn_s[i]) begin
            state_d[i] = ARMING;
            cnt_d[i]   = '0;
          end
        end
        ARMING: begin
          if (!btn_s[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = HELD;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s[i]) begin
            state_d[i] = RELEASING;
            cnt_d[i]   = '0;
          end
        end
        RELEASING: begin
          if (btn_s[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      press[i] = (state_q[i] == ARMING) && btn_s[i] &&
                 (cnt_q[i] == CntMax);
    end
  end

  logic left_evt, right_evt;

`ifdef AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RptMax =
    RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];
  logic [1:0]       rpt_on_q, rpt_on_d, rep;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rpt_q[0] <= '0;
      rpt_q[1] <= '0;
      rpt_on_q <= '0;
    end else begin
      rpt_q[0] <= rpt_d[0];
      rpt_q[1] <= rpt_d[1];
      rpt_on_q <= rpt_on_d;
    end
  end

  // rpt_on: only a HELD reached through an accepted press repeats
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rpt_d[j]    = '0;
      rpt_on_d[j] = 1'b0;
      rep[j]      = 1'b0;
      if (state_q[j+2] == HELD &&
          state_d[j+2] == HELD) begin
        rpt_on_d[j] = rpt_on_q[j];
        if (rpt_q[j] == RptMax) begin
          rep[j] = rpt_on_q[j];
        end else begin
          rpt_d[j] = rpt_q[j] + 1'b1;
        end
      end
      if (press[j+2]) begin
        rpt_on_d[j] = 1'b1;
      end
    end
  end

  assign left_evt  = press[2] | rep[0];
  assign right_evt = press[3] | rep[1];
`else
  assign left_evt  = press[2];
  assign right_evt = press[3];
`endif

  logic sel_q, quit_q, left_q, right_q;
  logic sel_d, quit_d, left_d, right_d;

  always_comb begin
    sel_d   = 1'b0;
    quit_d  = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    unique case (1'b1)
      press[1]: quit_d = 1'b1;
      default: begin
        sel_d = press[0];
        if (left_evt != right_evt) begin
          left_d  = left_evt;
          right_d = right_evt;
        end
      end
    endcase
  end

  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] swcnt_q, swcnt_d;
  logic [7:0]       num_q, num_d;
  logic             chg_q, chg_d;

  always_comb begin
    cand_d  = cand_q;
    swcnt_d = swcnt_q;
    num_d   = num_q;
    chg_d   = 1'b0;
    if (sw_s != cand_q) begin
      cand_d  = sw_s;
      swcnt_d = '0;
    end else if (swcnt_q != CntMax) begin
      swcnt_d = swcnt_q + 1'b1;
    end else if (cand_q != num_q) begin
      num_d = cand_q;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel_q   <= 1'b0;
      quit_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      cand_q  <= '0;
      swcnt_q <= '0;
      num_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      quit_q  <= quit_d;
      left_q  <= left_d;
      right_q <= right_d;
      cand_q  <= cand_d;
      swcnt_q <= swcnt_d;
      num_q   <= num_d;
      chg_q   <= chg_d;
    end
  end

  assign Select        = sel_q;
  assign Quit          = quit_q;
  assign selectLeft    = left_q;
  assign selectRight   = right_q;
  assign userNumber    = num_q;
  assign numberChanged = chg_q;

endmodule

// File: tb/tb_binary_game_input_ctrl.sv
// tb_binary_game_input_ctrl: directed scoreboard bench for
// binary_game_input_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.

module tb_binary_game_input_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       btnSelect, btnQuit, btnLeft, btnRight;
  logic [7:0] sw;
  logic       Select, Quit, selectLeft, selectRight;
  logic [7:0] userNumber;
  logic       numberChanged;

  binary_game_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4),
    .REPEAT_CYCLES(10)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .btnSelect(btnSelect),
    .btnQuit(btnQuit),
    .btnLeft(btnLeft),
    .btnRight(btnRight),
    .sw(sw),
    .Select(Select),
    .Quit(Quit),
    .selectLeft(selectLeft),
    .selectRight(selectRight),
    .userNumber(userNumber),
    .numberChanged(numberChanged)
  );

  always #5 Clk = ~Clk;

  // {Quit, Select, selectLeft, selectRight, numberChanged}
  localparam logic [4:0] P_Q = 5'b10000;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_L = 5'b00100;
  localparam logic [4:0] P_R = 5'b00010;
  localparam logic [4:0] P_C = 5'b00001;
  localparam int unsigned LAT = 7;

  typedef struct packed {
    int unsigned cyc;
    logic [4:0]  v;
    logic [7:0]  num;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          nchk = 0;
  int          nerr = 0;
  logic [7:0]  num_exp = 8'h00;
  string       tag = "init";

  task automatic expect_at(input int unsigned c,
                           input logic [4:0] v,
                           input logic [7:0] n);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.num = n;
    sbq.push_back(e);
  endtask

  task automatic tick();
    logic [4:0] ev;
    logic [4:0] ob;
    @(posedge Clk);
    #1;
    cyc++;
    ev = '0;
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      ev |= sbq[0].v;
      if (sbq[0].v[0]) num_exp = sbq[0].num;
      void'(sbq.pop_front());
    end
    ob = {Quit, Select, selectLeft, selectRight, numberChanged};
    nchk++;
    assert (ob === ev) else begin
      nerr++;
      $error("FAIL %s pulses cyc=%0d got=%b exp=%b",
             tag, cyc, ob, ev);
    end
    nchk++;
    assert (userNumber === num_exp) else begin
      nerr++;
      $error("FAIL %s userNumber cyc=%0d got=%h exp=%h",
             tag, cyc, userNumber, num_exp);
    end
  endtask

  task automatic hold_release(input int h);
    repeat (h) tick();
    btnSelect = 1'b0;
    btnQuit   = 1'b0;
    btnLeft   = 1'b0;
    btnRight  = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    Reset     = 1'b0;
    btnSelect = 1'b0;
    btnQuit   = 1'b0;
    btnLeft   = 1'b0;
    btnRight  = 1'b0;
    sw        = 8'h00;
    tag = "reset";
    repeat (5) tick();
    Reset = 1'b1;
    tag = "idle";
    repeat (20) tick();

    tag = "select1";
    btnSelect = 1'b1;
    expect_at(cyc + LAT, P_S, num_exp);
    hold_release(20);

    tag = "select2";
    btnSelect = 1'b1;
    expect_at(cyc + LAT, P_S, num_exp);
    hold_release(12);

    tag = "left_bounce";
    btnLeft = 1'b1; tick();
    btnLeft = 1'b0; tick();
    btnLeft = 1'b1; tick();
    btnLeft = 1'b0; tick();
    btnLeft = 1'b1;
    expect_at(cyc + LAT, P_L, num_exp);
    hold_release(12);

    tag = "quit_right";
    btnQuit  = 1'b1;
    btnRight = 1'b1;
    expect_at(cyc + LAT, P_Q, num_exp);
    hold_release(12);

    tag = "sel_left";
    btnSelect = 1'b1;
    btnLeft   = 1'b1;
    expect_at(cyc + LAT, P_S | P_L, num_exp);
    hold_release(12);

    tag = "left_right";
    btnLeft  = 1'b1;
    btnRight = 1'b1;
    hold_release(12);

    tag = "sw_bounce";
    sw = 8'hA4; tick();
    sw = 8'hA5; tick();
    sw = 8'hA4; tick();
    sw = 8'hA5;
    expect_at(cyc + LAT, P_C, 8'hA5);
    repeat (15) tick();

    tag = "reset_mid";
    btnRight = 1'b1;
    repeat (4) tick();
    Reset = 1'b0;
    sbq.delete();
    num_exp = 8'h00;
    repeat (3) tick();
    Reset = 1'b1;
    expect_at(cyc + LAT, P_C, 8'hA5);
    repeat (20) tick();
    btnRight = 1'b0;
    repeat (10) tick();
    tag = "repress";
    btnRight = 1'b1;
    expect_at(cyc + LAT, P_R, num_exp);
    hold_release(12);

`ifdef AUTOREPEAT_EN
    tag = "autorepeat";
    btnRight = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_at(cyc + LAT + 10 * k, P_R, num_exp);
    end
    hold_release(42);
`endif

    tag = "drain";
    nchk++;
    assert (sbq.size() == 0) else begin
      nerr++;
      $error("FAIL %s pending got=%0d exp=0", tag, sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
